// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: either a single register or a 2-entry skid buffer.
// An all-zero control payload is a bubble, so head ctrl is cleared whenever the stage empties.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        occ;
    logic              accept;
    logic              pop;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign occupancy = occ;

    generate
        if (SKID != 0) begin : g_skid
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;
            logic              ready_q;

            // ready_q mirrors (occ != 2) as a flop so out_ready never reaches in_ready.
            assign in_ready = ready_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    occ       <= 2'd0;
                    head_ctrl <= '0;
                    head_data <= '0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                    ready_q   <= 1'b1;
                end else if (flush) begin
                    occ       <= 2'd0;
                    head_ctrl <= '0;
                    skid_ctrl <= '0;
                    ready_q   <= 1'b1;
                end else begin
                    case (occ)
                        2'd0: begin
                            if (accept) begin
                                head_ctrl <= in_ctrl;
                                head_data <= in_data;
                                occ       <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (accept && pop) begin
                                head_ctrl <= in_ctrl;
                                head_data <= in_data;
                            end else if (accept) begin
                                skid_ctrl <= in_ctrl;
                                skid_data <= in_data;
                                occ       <= 2'd2;
                                ready_q   <= 1'b0;
                            end else if (pop) begin
                                head_ctrl <= '0;
                                occ       <= 2'd0;
                            end
                        end
                        2'd2: begin
                            if (pop) begin
                                head_ctrl <= skid_ctrl;
                                head_data <= skid_data;
                                skid_ctrl <= '0;
                                occ       <= 2'd1;
                                ready_q   <= 1'b1;
                            end
                        end
                        default: begin
                            occ       <= 2'd0;
                            head_ctrl <= '0;
                            skid_ctrl <= '0;
                            ready_q   <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // A full single register can take a new entry only in the cycle its head leaves.
            assign in_ready = ~out_valid | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    occ       <= 2'd0;
                    head_ctrl <= '0;
                    head_data <= '0;
                end else if (flush) begin
                    occ       <= 2'd0;
                    head_ctrl <= '0;
                end else if (accept) begin
                    head_ctrl <= in_ctrl;
                    head_data <= in_data;
                    occ       <= 2'd1;
                end else if (pop) begin
                    head_ctrl <= '0;
                    occ       <= 2'd0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench driving a skid-buffer instance (index 0) and a single-register instance (index 1)
// with shared stimulus, checked every cycle against a bounded-FIFO model of each.
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          dut_in_ready  [2];
    logic          dut_out_valid [2];
    logic [CW-1:0] dut_out_ctrl  [2];
    logic [DW-1:0] dut_out_data  [2];
    logic [1:0]    dut_occ       [2];

    int tests_run = 0;
    int fail_count = 0;

    // Model state: each stage is a FIFO of capacity 2 (skid) or 1 (single register).
    logic [CW-1:0] m_ctrl [2][2];
    logic [DW-1:0] m_data [2][2];
    int            m_count [2];
    logic          m_zero  [2];

    logic          cap_en = 1'b0;
    logic [31:0]   cap_q [$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(dut_in_ready[0]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(dut_out_valid[0]), .out_ready(out_ready),
        .out_ctrl(dut_out_ctrl[0]), .out_data(dut_out_data[0]),
        .occupancy(dut_occ[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(dut_in_ready[1]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(dut_out_valid[1]), .out_ready(out_ready),
        .out_ctrl(dut_out_ctrl[1]), .out_data(dut_out_data[1]),
        .occupancy(dut_occ[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic applyStimulus(input logic r, input logic f, input logic v, input logic o,
                                 input logic [CW-1:0] c, input logic [DW-1:0] d);
        rst       = r;
        flush     = f;
        in_valid  = v;
        out_ready = o;
        in_ctrl   = c;
        in_data   = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare against the model on each falling edge, then advance the model by the
    // inputs that the coming rising edge will sample.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0;
            m_zero[k]  = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic          exp_valid;
                logic          exp_ready;
                logic [CW-1:0] exp_ctrl;
                logic          rdy;
                logic          acc;
                logic          pp;
                exp_valid = (m_count[k] != 0);
                exp_ready = (k == 0) ? (m_count[k] != 2) : (m_count[k] == 0 || out_ready);
                exp_ctrl  = exp_valid ? m_ctrl[k][0] : '0;
                checkOutput($sformatf("model_occ[%0d]", k), DW'(dut_occ[k]), DW'(m_count[k]));
                checkOutput($sformatf("model_valid[%0d]", k), DW'(dut_out_valid[k]), DW'(exp_valid));
                checkOutput($sformatf("model_ready[%0d]", k), DW'(dut_in_ready[k]), DW'(exp_ready));
                checkOutput($sformatf("model_ctrl[%0d]", k), DW'(dut_out_ctrl[k]), DW'(exp_ctrl));
                if (exp_valid)
                    checkOutput($sformatf("model_data[%0d]", k), dut_out_data[k], m_data[k][0]);
                else if (m_zero[k])
                    checkOutput($sformatf("model_data0[%0d]", k), dut_out_data[k], '0);

                if (rst) begin
                    m_count[k] = 0;
                    m_zero[k]  = 1'b1;
                end else if (flush) begin
                    m_count[k] = 0;
                end else begin
                    rdy = exp_ready;
                    acc = in_valid && rdy;
                    pp  = (m_count[k] != 0) && out_ready;
                    if (pp) begin
                        m_ctrl[k][0] = m_ctrl[k][1];
                        m_data[k][0] = m_data[k][1];
                        m_count[k]--;
                    end
                    if (acc) begin
                        m_ctrl[k][m_count[k]] = in_ctrl;
                        m_data[k][m_count[k]] = in_data;
                        m_count[k]++;
                        m_zero[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Record what the single-register stage hands downstream during the toggle test.
    initial begin
        forever begin
            @(negedge clk);
            if (cap_en && dut_out_valid[1] && out_ready)
                cap_q.push_back(dut_out_data[1][31:0]);
        end
    end

    initial begin
        logic [DW-1:0] a_val;
        logic [DW-1:0] b_val;
        logic [DW-1:0] c_val;

        a_val = {5{32'hAAAA_0001}};
        b_val = {5{32'hBBBB_0002}};
        c_val = {5{32'hCCCC_0003}};

        applyStimulus(1, 0, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 1, 8'h5A, rand_data());
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset_occ[%0d]", k), DW'(dut_occ[k]), '0);
            checkOutput($sformatf("reset_ready[%0d]", k), DW'(dut_in_ready[k]), DW'(1));
            checkOutput($sformatf("reset_ctrl[%0d]", k), DW'(dut_out_ctrl[k]), '0);
            checkOutput($sformatf("reset_data[%0d]", k), dut_out_data[k], '0);
        end

        // Streaming: one entry per cycle, each visible right after its accepting edge.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 1, 1, 8'h01, DW'(k));
            checkOutput("stream_data", dut_out_data[0], DW'(k));
            checkOutput("stream_occ", DW'(dut_occ[0]), DW'(1));
            checkOutput("stream_ready", DW'(dut_in_ready[0]), DW'(1));
        end
        applyStimulus(0, 0, 0, 1, '0, '0);
        checkOutput("drain_occ", DW'(dut_occ[0]), '0);
        checkOutput("drain_ctrl", DW'(dut_out_ctrl[0]), '0);

        // Backpressure fills the skid entry, then releases A before B.
        applyStimulus(0, 0, 1, 0, 8'h0A, a_val);
        applyStimulus(0, 0, 1, 0, 8'h0B, b_val);
        checkOutput("bp_occ", DW'(dut_occ[0]), DW'(2));
        checkOutput("bp_ready", DW'(dut_in_ready[0]), '0);
        checkOutput("bp_head", dut_out_data[0], a_val);
        applyStimulus(0, 0, 0, 1, '0, '0);
        checkOutput("bp_second", dut_out_data[0], b_val);
        checkOutput("bp_occ1", DW'(dut_occ[0]), DW'(1));
        applyStimulus(0, 0, 0, 1, '0, '0);
        checkOutput("bp_occ0", DW'(dut_occ[0]), '0);

        // Flush with a concurrent accept drops everything, including the FF entry.
        applyStimulus(0, 0, 1, 0, 8'h11, rand_data());
        applyStimulus(0, 0, 1, 0, 8'h22, rand_data());
        applyStimulus(0, 1, 1, 0, 8'hFF, rand_data());
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("flush_occ[%0d]", k), DW'(dut_occ[k]), '0);
            checkOutput($sformatf("flush_valid[%0d]", k), DW'(dut_out_valid[k]), '0);
            checkOutput($sformatf("flush_ctrl[%0d]", k), DW'(dut_out_ctrl[k]), '0);
        end
        applyStimulus(0, 0, 0, 1, '0, '0);
        checkOutput("flush_after", DW'(dut_out_valid[0]), '0);

        // Reset mid-stream, then C must be the first thing out.
        applyStimulus(0, 0, 1, 0, 8'h33, rand_data());
        applyStimulus(0, 0, 1, 0, 8'h44, rand_data());
        applyStimulus(1, 0, 1, 1, 8'h55, rand_data());
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("midrst_occ[%0d]", k), DW'(dut_occ[k]), '0);
            checkOutput($sformatf("midrst_ctrl[%0d]", k), DW'(dut_out_ctrl[k]), '0);
            checkOutput($sformatf("midrst_data[%0d]", k), dut_out_data[k], '0);
            checkOutput($sformatf("midrst_ready[%0d]", k), DW'(dut_in_ready[k]), DW'(1));
        end
        applyStimulus(0, 0, 1, 0, 8'h0C, c_val);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("midrst_first[%0d]", k), dut_out_data[k], c_val);
            checkOutput($sformatf("midrst_cocc[%0d]", k), DW'(dut_occ[k]), DW'(1));
        end
        applyStimulus(0, 0, 0, 1, '0, '0);

        // Single register with out_ready toggling: accepts land on even cycles only.
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 40; i++)
            applyStimulus(0, 0, 1, (i % 2 == 0), 8'h01, DW'(100 + i));
        applyStimulus(0, 0, 0, 1, '0, '0);
        cap_en = 1'b0;
        checkOutput("toggle_count", DW'(cap_q.size()), DW'(20));
        for (int j = 0; j < cap_q.size() && j < 20; j++)
            checkOutput($sformatf("toggle_item%0d", j), DW'(cap_q[j]), DW'(100 + 2 * j));

        // Random traffic with occasional flush and rare reset.
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                          CW'($urandom), rand_data());
        end

        applyStimulus(0, 0, 0, 1, '0, '0);
        applyStimulus(0, 0, 0, 1, '0, '0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
